dcp_noc2_arb: RTL and testbench
===============================

# dcp_noc2_arb

Round-robin arbiter that shares the single NoC2 request buffer (`dcp_noc2buffer`) between several DCP request sources, such as load-response, TLB-fill and config-access paths. It selects one valid requester per cycle and forwards its NoC2 request fields to the buffer. It returns the buffer's ack to the winner only. A registered grant lock keeps a stalled request stable at the buffer input until the buffer accepts it.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..8.
- `PRIO_LIMIT`, default 4: maximum consecutive requester-0 grants while others are pending. Used only when `DCP_NOC2_ARB_PRIO_EN` is defined; legal range 1..15.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset; one clock, synchronous, active-low.
- `req_val`  in  `NUM_REQ`: per-requester request valid.
- `req_type`  in  `NUM_REQ*DCP_NOC2_REQTYPE_WIDTH`: flattened; requester i occupies slice i.
- `req_data`  in  `NUM_REQ*NOC_DATA_WIDTH`: flattened.
- `req_mshrid`  in  `NUM_REQ*DCP_MSHRID_WIDTH`: flattened.
- `req_address`  in  `NUM_REQ*PHY_ADDR_WIDTH`: flattened.
- `req_homeid`  in  `NUM_REQ*PACKET_HOME_ID_WIDTH`: flattened.
- `req_fbits`  in  `NUM_REQ*MSG_SRC_FBITS_WIDTH`: flattened.
- `req_ack`  out  `NUM_REQ`: one-hot-or-zero; the winner's request is accepted this cycle.
- `noc2buffer_val`  out  1: request valid to the buffer.
- `noc2buffer_type`, `_data`, `_mshrid`, `_address`, `_homeid`, `_fbits`  out  matching widths: the winner's fields.
- `noc2buffer_ack`  in  1: the buffer accepted the presented request.

## Operation
- Requester rule: once `req_val[i]` rises, it holds with stable fields until `req_ack[i]`.
- Registered state:
  - `rr_ptr` (log2 `NUM_REQ` bits): highest-priority index.
  - `lock_val` (1 bit) and `lock_idx`: grant lock.
  - `prio_cnt` (4 bits): macro builds only.
- Winner selection:
  - If `lock_val` is set, the winner is `lock_idx`.
  - Otherwise, search for the first set `req_val` bit starting at `rr_ptr`, wrapping modulo `NUM_REQ`.
- Output fields:
  - `noc2buffer_val` = at least one `req_val` bit set, and `rst_n` high.
  - All field outputs are muxed from the winner. They are don't-care when `noc2buffer_val` is 0.
- Ack routing: `req_ack[w]` = `noc2buffer_ack & noc2buffer_val`; all other bits are 0.
- Lock:
  - Set with `lock_idx`=w when `noc2buffer_val & !noc2buffer_ack`.
  - Cleared on the cycle the ack occurs.
- Pointer:
  - On an accepted handshake, `rr_ptr` ← (w+1) mod `NUM_REQ`.
  - Otherwise `rr_ptr` is unchanged.
- Reset, including mid-lock:
  - `rr_ptr`=0, `lock_val`=0, `prio_cnt`=0.
  - While `rst_n` is low, `noc2buffer_val`=0 and `req_ack`=0.
  - A pending request is re-arbitrated from index 0 after reset.

## Timing
- Zero-cycle latency: grant, forwarded fields and `req_ack` are combinational from the same-cycle inputs and state.
- State updates on the next `clk` edge.
- Full throughput: one accepted request per cycle when `noc2buffer_ack` stays high.
- Back-pressure: the winner and its fields stay constant every cycle until ack. A newly asserted lower-index request cannot preempt it.
- Simultaneous ack and new requests: the pointer advance and lock clear take effect next cycle. The following winner is chosen from the updated `rr_ptr`.
- Single requester: granted every cycle it is valid; `rr_ptr` wraps (`NUM_REQ`-1 → 0).
- Empty (`req_val`=0): `noc2buffer_val`=0 and no state changes.

## Configuration
- Macro: `DCP_NOC2_ARB_PRIO_EN`.
- Defined — requester 0 has bounded strict priority:
  - When not locked and `req_val[0]` is set, requester 0 wins, unless `prio_cnt`==`PRIO_LIMIT` and another requester is valid.
  - In that case the winner is chosen round-robin among requesters 1..`NUM_REQ`-1 starting at `rr_ptr`; index 0 is skipped.
  - `prio_cnt` increments on each accepted requester-0 grant while any other `req_val` is set.
  - `prio_cnt` clears on any accepted non-0 grant, or when no other requester is valid.
  - `prio_cnt` saturates at `PRIO_LIMIT`.
- Undefined: pure round-robin over all requesters; `prio_cnt` and `PRIO_LIMIT` logic are not built.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `req_val`=4'b1111 → `noc2buffer_val`=0 and `req_ack`=0. After release, the first grant is requester 0.
- Round-robin, macro undefined: `req_val`=4'b1111 held, `noc2buffer_ack`=1 → `req_ack` sequence is 0001, 0010, 0100, 1000, 0001.
- Back-pressure lock: requester 1 presented with `noc2buffer_ack`=0 for 3 cycles, and `req_val[0]` rises in cycle 2 → fields stay equal to requester 1's. The ack in cycle 4 gives `req_ack`=0010; the next grant is requester 0 (wrap search from `rr_ptr`=2 finds 0).
- Single requester: only `req_val[3]` high for 5 cycles with ack=1 → 5 consecutive `req_ack`=1000; `rr_ptr` stays 0.
- Priority, macro defined, `PRIO_LIMIT`=4: requesters 0 and 2 continuously valid, ack=1 → grant order is 0, 0, 0, 0, 2, 0, 0, 0, 0, 2.
- Reset mid-lock: lock held on requester 2, then `rst_n`=0 for 1 cycle → `lock_val`=0 and `rr_ptr`=0. If requesters 0 and 2 are still valid, requester 0 wins first.

Source files
------------

// File: rtl/dcp_noc2_arb_if.sv
// Bundle between the DCP NoC2 request sources, dcp_noc2_arb and dcp_noc2buffer.
// The master modport is the environment side and the slave modport is the arbiter side.
interface dcp_noc2_arb_if #(
  parameter int NUM_REQ                = 4,
  parameter int DCP_NOC2_REQTYPE_WIDTH = 3,
  parameter int NOC_DATA_WIDTH         = 64,
  parameter int DCP_MSHRID_WIDTH       = 8,
  parameter int PHY_ADDR_WIDTH         = 40,
  parameter int PACKET_HOME_ID_WIDTH   = 30,
  parameter int MSG_SRC_FBITS_WIDTH    = 4
);
  logic [NUM_REQ-1:0]                        req_val;
  logic [NUM_REQ*DCP_NOC2_REQTYPE_WIDTH-1:0] req_type;
  logic [NUM_REQ*NOC_DATA_WIDTH-1:0]         req_data;
  logic [NUM_REQ*DCP_MSHRID_WIDTH-1:0]       req_mshrid;
  logic [NUM_REQ*PHY_ADDR_WIDTH-1:0]         req_address;
  logic [NUM_REQ*PACKET_HOME_ID_WIDTH-1:0]   req_homeid;
  logic [NUM_REQ*MSG_SRC_FBITS_WIDTH-1:0]    req_fbits;
  logic [NUM_REQ-1:0]                        req_ack;

  logic                              noc2buffer_val;
  logic [DCP_NOC2_REQTYPE_WIDTH-1:0] noc2buffer_type;
  logic [NOC_DATA_WIDTH-1:0]         noc2buffer_data;
  logic [DCP_MSHRID_WIDTH-1:0]       noc2buffer_mshrid;
  logic [PHY_ADDR_WIDTH-1:0]         noc2buffer_address;
  logic [PACKET_HOME_ID_WIDTH-1:0]   noc2buffer_homeid;
  logic [MSG_SRC_FBITS_WIDTH-1:0]    noc2buffer_fbits;
  logic                              noc2buffer_ack;

  modport master (
    output req_val, req_type, req_data, req_mshrid, req_address, req_homeid, req_fbits,
    output noc2buffer_ack,
    input  req_ack,
    input  noc2buffer_val, noc2buffer_type, noc2buffer_data, noc2buffer_mshrid,
    input  noc2buffer_address, noc2buffer_homeid, noc2buffer_fbits
  );

  modport slave (
    input  req_val, req_type, req_data, req_mshrid, req_address, req_homeid, req_fbits,
    input  noc2buffer_ack,
    output req_ack,
    output noc2buffer_val, noc2buffer_type, noc2buffer_data, noc2buffer_mshrid,
    output noc2buffer_address, noc2buffer_homeid, noc2buffer_fbits
  );
endinterface

// File: rtl/dcp_noc2_arb.sv
// Round-robin arbiter sharing the single dcp_noc2buffer among DCP request sources.
// Define DCP_NOC2_ARB_PRIO_EN to give requester 0 bounded strict priority (PRIO_LIMIT grants).
module dcp_noc2_arb #(
  parameter int NUM_REQ                = 4,
  parameter int PRIO_LIMIT             = 4,
  parameter int DCP_NOC2_REQTYPE_WIDTH = 3,
  parameter int NOC_DATA_WIDTH         = 64,
  parameter int DCP_MSHRID_WIDTH       = 8,
  parameter int PHY_ADDR_WIDTH         = 40,
  parameter int PACKET_HOME_ID_WIDTH   = 30,
  parameter int MSG_SRC_FBITS_WIDTH    = 4
) (
  input logic           clk,
  input logic           rst_n,
  dcp_noc2_arb_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [DCP_NOC2_REQTYPE_WIDTH-1:0] rtype;
    logic [NOC_DATA_WIDTH-1:0]         data;
    logic [DCP_MSHRID_WIDTH-1:0]       mshrid;
    logic [PHY_ADDR_WIDTH-1:0]         address;
    logic [PACKET_HOME_ID_WIDTH-1:0]   homeid;
    logic [MSG_SRC_FBITS_WIDTH-1:0]    fbits;
  } noc2_req_t;

  typedef enum logic {
    LOCK_FREE,
    LOCK_HELD
  } lock_state_t;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("dcp_noc2_arb: NUM_REQ must be in 2..8");
  end
  if (PRIO_LIMIT < 1 || PRIO_LIMIT > 15) begin : g_bad_prio_limit
    $error("dcp_noc2_arb: PRIO_LIMIT must be in 1..15");
  end

  noc2_req_t   req_arr [NUM_REQ];
  noc2_req_t   win_req;
  lock_state_t lock_state_q, lock_state_d;
  logic        lock_val;
  idx_t        lock_idx, lock_idx_d;
  idx_t        rr_ptr, rr_ptr_d;
  idx_t        win;
  logic        any_val;
  logic        handshake;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_arr[i] = '{
      rtype:   bus.req_type   [i*DCP_NOC2_REQTYPE_WIDTH +: DCP_NOC2_REQTYPE_WIDTH],
      data:    bus.req_data   [i*NOC_DATA_WIDTH         +: NOC_DATA_WIDTH],
      mshrid:  bus.req_mshrid [i*DCP_MSHRID_WIDTH       +: DCP_MSHRID_WIDTH],
      address: bus.req_address[i*PHY_ADDR_WIDTH         +: PHY_ADDR_WIDTH],
      homeid:  bus.req_homeid [i*PACKET_HOME_ID_WIDTH   +: PACKET_HOME_ID_WIDTH],
      fbits:   bus.req_fbits  [i*MSG_SRC_FBITS_WIDTH    +: MSG_SRC_FBITS_WIDTH]
    };
  end

  // First set bit of val at or after ptr, wrapping; returns 0 when val is empty.
  function automatic idx_t rr_pick(input logic [NUM_REQ-1:0] val, input idx_t ptr);
    idx_t pick;
    idx_t pos;
    logic found;
    int   sum;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      pos = idx_t'(sum);
      if (!found && val[pos]) begin
        found = 1'b1;
        pick  = pos;
      end
    end
    return pick;
  endfunction

  assign any_val   = |bus.req_val;
  assign lock_val  = (lock_state_q == LOCK_HELD);
  assign handshake = bus.noc2buffer_val & bus.noc2buffer_ack;

`ifdef DCP_NOC2_ARB_PRIO_EN
  logic [3:0] prio_cnt, prio_cnt_d;
  logic       others_val;
  logic       prio_sat;

  assign others_val = |bus.req_val[NUM_REQ-1:1];
  assign prio_sat   = (prio_cnt == 4'(PRIO_LIMIT));
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
`ifdef DCP_NOC2_ARB_PRIO_EN
    logic [NUM_REQ-1:0] cand_val;
    cand_val    = bus.req_val;
    cand_val[0] = 1'b0;
    // Requester 0 is skipped in the search; it either wins outright or yields to the others.
    win = rr_pick(cand_val, rr_ptr);
    if (bus.req_val[0] && !(prio_sat && others_val)) win = '0;
`else
    win = rr_pick(bus.req_val, rr_ptr);
`endif
    if (lock_val) win = lock_idx;
  end

  assign win_req = req_arr[win];

  assign bus.noc2buffer_val     = rst_n & any_val;
  assign bus.noc2buffer_type    = win_req.rtype;
  assign bus.noc2buffer_data    = win_req.data;
  assign bus.noc2buffer_mshrid  = win_req.mshrid;
  assign bus.noc2buffer_address = win_req.address;
  assign bus.noc2buffer_homeid  = win_req.homeid;
  assign bus.noc2buffer_fbits   = win_req.fbits;

  always_comb begin
    bus.req_ack = '0;
    if (handshake) bus.req_ack[win] = 1'b1;
  end

  // A stalled grant is pinned so the buffer input cannot change under back-pressure.
  always_comb begin
    lock_state_d = lock_state_q;
    lock_idx_d   = lock_idx;
    case (lock_state_q)
      LOCK_FREE: begin
        if (bus.noc2buffer_val && !bus.noc2buffer_ack) begin
          lock_state_d = LOCK_HELD;
          lock_idx_d   = win;
        end
      end
      LOCK_HELD: begin
        if (handshake) lock_state_d = LOCK_FREE;
      end
      default: lock_state_d = LOCK_FREE;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr;
    if (handshake) rr_ptr_d = (win == idx_t'(NUM_REQ - 1)) ? '0 : win + idx_t'(1);
  end

  // NOTE: state registers use <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_state_q <= LOCK_FREE;
      lock_idx     <= '0;
      rr_ptr       <= '0;
    end else begin
      lock_state_q <= lock_state_d;
      lock_idx     <= lock_idx_d;
      rr_ptr       <= rr_ptr_d;
    end
  end

`ifdef DCP_NOC2_ARB_PRIO_EN
  always_comb begin
    prio_cnt_d = prio_cnt;
    if (!others_val) begin
      prio_cnt_d = '0;
    end else if (handshake) begin
      if (win != '0)     prio_cnt_d = '0;
      else if (!prio_sat) prio_cnt_d = prio_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) prio_cnt <= '0;
    else        prio_cnt <= prio_cnt_d;
  end
`endif

endmodule

// File: tb/tb_dcp_noc2_arb.sv
// Directed bench for dcp_noc2_arb: reset, round-robin, back-pressure lock, wrap, empty,
// reset during a lock, and (with DCP_NOC2_ARB_PRIO_EN) bounded requester-0 priority.
module tb_dcp_noc2_arb;
  localparam int N    = 4;
  localparam int TW   = 3;
  localparam int DW   = 64;
  localparam int MW   = 8;
  localparam int AW   = 40;
  localparam int HW   = 30;
  localparam int FW   = 4;
  localparam int PLIM = 4;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  dcp_noc2_arb_if #(
    .NUM_REQ(N), .DCP_NOC2_REQTYPE_WIDTH(TW), .NOC_DATA_WIDTH(DW), .DCP_MSHRID_WIDTH(MW),
    .PHY_ADDR_WIDTH(AW), .PACKET_HOME_ID_WIDTH(HW), .MSG_SRC_FBITS_WIDTH(FW)
  ) bus ();

  dcp_noc2_arb #(
    .NUM_REQ(N), .PRIO_LIMIT(PLIM), .DCP_NOC2_REQTYPE_WIDTH(TW), .NOC_DATA_WIDTH(DW),
    .DCP_MSHRID_WIDTH(MW), .PHY_ADDR_WIDTH(AW), .PACKET_HOME_ID_WIDTH(HW),
    .MSG_SRC_FBITS_WIDTH(FW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [TW-1:0] f_type(input int i);   return TW'(i + 1);                       endfunction
  function automatic logic [DW-1:0] f_data(input int i);   return {16'hDA7A, 16'(i), 32'h600D_0000 + 32'(i)}; endfunction
  function automatic logic [MW-1:0] f_mshrid(input int i); return 8'h40 + 8'(i);                    endfunction
  function automatic logic [AW-1:0] f_addr(input int i);   return 40'hA0_0000_1000 + (40'(i) << 6); endfunction
  function automatic logic [HW-1:0] f_home(input int i);   return 30'h100 + 30'(i);                 endfunction
  function automatic logic [FW-1:0] f_fbits(input int i);  return 4'(i + 8);                        endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check outputs mid-cycle, then let the edge happen; exp_win < 0 skips the field checks.
  task automatic step(input string tag, input logic [N-1:0] exp_ack, input logic exp_val,
                      input int exp_win);
    @(negedge clk);
    check($sformatf("%s_ack", tag), 64'(bus.req_ack), 64'(exp_ack));
    check($sformatf("%s_val", tag), 64'(bus.noc2buffer_val), 64'(exp_val));
    if (exp_win >= 0) begin
      check($sformatf("%s_type", tag),   64'(bus.noc2buffer_type),    64'(f_type(exp_win)));
      check($sformatf("%s_data", tag),   bus.noc2buffer_data,         f_data(exp_win));
      check($sformatf("%s_mshrid", tag), 64'(bus.noc2buffer_mshrid),  64'(f_mshrid(exp_win)));
      check($sformatf("%s_addr", tag),   64'(bus.noc2buffer_address), 64'(f_addr(exp_win)));
      check($sformatf("%s_homeid", tag), 64'(bus.noc2buffer_homeid),  64'(f_home(exp_win)));
      check($sformatf("%s_fbits", tag),  64'(bus.noc2buffer_fbits),   64'(f_fbits(exp_win)));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.req_val        = '0;
    bus.noc2buffer_ack = 1'b0;
    for (int i = 0; i < N; i++) begin
      bus.req_type   [i*TW +: TW] = f_type(i);
      bus.req_data   [i*DW +: DW] = f_data(i);
      bus.req_mshrid [i*MW +: MW] = f_mshrid(i);
      bus.req_address[i*AW +: AW] = f_addr(i);
      bus.req_homeid [i*HW +: HW] = f_home(i);
      bus.req_fbits  [i*FW +: FW] = f_fbits(i);
    end

    // Reset held with every requester pending and the buffer ready.
    bus.req_val        = 4'b1111;
    bus.noc2buffer_ack = 1'b1;
    repeat (3) step("reset", 4'b0000, 1'b0, -1);
    rst_n = 1'b1;
    step("first", 4'b0001, 1'b1, 0);
`ifndef DCP_NOC2_ARB_PRIO_EN
    step("rr1", 4'b0010, 1'b1, 1);
    step("rr2", 4'b0100, 1'b1, 2);
    step("rr3", 4'b1000, 1'b1, 3);
    step("rr4", 4'b0001, 1'b1, 0);
`endif

    // Back-pressure: requester 1 stalls three cycles; requester 0 arrives and must wait.
    bus.req_val        = 4'b0010;
    bus.noc2buffer_ack = 1'b0;
    step("bp_c1", 4'b0000, 1'b1, 1);
    bus.req_val = 4'b0011;
    step("bp_c2", 4'b0000, 1'b1, 1);
    step("bp_c3", 4'b0000, 1'b1, 1);
    bus.noc2buffer_ack = 1'b1;
    step("bp_ack", 4'b0010, 1'b1, 1);
    bus.req_val = 4'b0001;
    step("bp_next", 4'b0001, 1'b1, 0);

    // Lone requester 3 every cycle; pointer wraps back to 0.
    bus.req_val = 4'b1000;
    for (int c = 0; c < 5; c++) step($sformatf("single%0d", c), 4'b1000, 1'b1, 3);
    bus.req_val = 4'b1111;
    step("after_wrap", 4'b0001, 1'b1, 0);

    // Empty cycle must not move the pointer (still 1 afterwards).
    bus.req_val = 4'b0000;
    step("empty", 4'b0000, 1'b0, -1);
    bus.req_val = 4'b1100;
    step("empty_hold", 4'b0100, 1'b1, 2);

    // Lock on requester 2, then reset in the middle of the lock.
    bus.req_val        = 4'b0100;
    bus.noc2buffer_ack = 1'b0;
    step("ml_lock", 4'b0000, 1'b1, 2);
    bus.req_val = 4'b0101;
    step("ml_hold", 4'b0000, 1'b1, 2);
    rst_n = 1'b0;
    step("ml_rst", 4'b0000, 1'b0, -1);
    rst_n              = 1'b1;
    bus.noc2buffer_ack = 1'b1;
    step("ml_first", 4'b0001, 1'b1, 0);
`ifdef DCP_NOC2_ARB_PRIO_EN
    step("ml_second", 4'b0001, 1'b1, 0);

    // Bounded priority from a clean state: four requester-0 grants, then requester 2.
    rst_n = 1'b0;
    step("prio_rst", 4'b0000, 1'b0, -1);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 4 || c == 9) step($sformatf("prio%0d", c), 4'b0100, 1'b1, 2);
      else                  step($sformatf("prio%0d", c), 4'b0001, 1'b1, 0);
    end
`else
    step("ml_second", 4'b0100, 1'b1, 2);
    step("alt0", 4'b0001, 1'b1, 0);
    step("alt2", 4'b0100, 1'b1, 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
